// File: rtl/gps_uart_rx.sv
// gps_uart_rx: 8N1 serial receiver (LSB first) for a GPS module TX line, with start/stop framing checks.
// Latency: uart_valid/frame_err rise 2 (sync) + 1 clks after the stop-bit vote point (~9.5 bit times after start edge).
// Backpressure: none; each byte is a one-cycle strobe, and the consumer must take it in that cycle.
module gps_uart_rx #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 9600,
  parameter int OVERSAMPLE  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] uart_data,
  output logic       uart_valid,
  output logic       frame_err,
  output logic       busy
);

  // Tick divider: integer floor of clk per sample tick, never below one clk.
  localparam int DIV_RAW = CLK_FREQ_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW      = $clog2(OVERSAMPLE);

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  // Three samples around mid-bit; the vote is resolved on the last of them.
  localparam logic [TW-1:0] MID_A     = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] MID_B     = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] MID_C     = TW'(OVERSAMPLE / 2 + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic            rx_m;
  logic            rx_s;
  // Shadow of the synchronizer marking when rx_s carries a real line sample
  // rather than the reset value.
  logic            vld_m;
  logic            vld_s;
  // Previous real sample was high; a start edge needs the line seen high first.
  logic            line_hi;

  logic [DW-1:0]   div_cnt;
  logic [TW-1:0]   tick_cnt;
  logic [2:0]      bit_cnt;
  logic            samp_a;
  logic            samp_b;
  logic [7:0]      shreg;

  logic            tick;
  logic            at_vote;
  logic            at_end;
  logic            vote;

  logic            clr_cnt;
  logic            shift_en;
  logic            load_data;
  logic            ferr_set;

  assign busy    = (state != S_IDLE);
  assign tick    = busy && (div_cnt == DIV_LAST);
  assign at_vote = tick && (tick_cnt == MID_C);
  assign at_end  = tick && (tick_cnt == TICK_LAST);
  // 2-of-3 majority of the two stored samples and the current one.
  assign vote    = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);

  // Two-flop synchronizer plus its valid shadow and the line-seen-high flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      vld_m   <= 1'b0;
      vld_s   <= 1'b0;
      line_hi <= 1'b0;
    end else begin
      rx_m    <= rx_in;
      rx_s    <= rx_m;
      vld_m   <= 1'b1;
      vld_s   <= vld_m;
      line_hi <= vld_s & rx_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    clr_cnt   = 1'b0;
    shift_en  = 1'b0;
    load_data = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      S_IDLE: begin
        if (line_hi && !rx_s) begin
          state_nxt = S_START;
          clr_cnt   = 1'b1;
        end
      end
      S_START: begin
        if (at_vote && vote) begin
          // Start bit did not hold low through mid-bit: treat as a glitch.
          state_nxt = S_IDLE;
        end else if (at_end) begin
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (at_vote) begin
          shift_en = 1'b1;
        end
        if (at_end && (bit_cnt == 3'd7)) begin
          state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        // Decide at mid stop bit so a back-to-back start edge is not missed.
        if (at_vote) begin
          if (vote) begin
            load_data = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            ferr_set  = 1'b1;
            state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rx_s) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Clock divider: runs only while busy, restarts on each start detect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (!busy || clr_cnt || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Sample-tick counter within a bit and the data bit counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
      bit_cnt  <= 3'd0;
    end else if (clr_cnt) begin
      tick_cnt <= '0;
      bit_cnt  <= 3'd0;
    end else begin
      if (tick) begin
        tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
      end
      if (at_end && (state == S_DATA)) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  // Capture the first two mid-bit samples and shift voted data bits in LSB first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp_a <= 1'b0;
      samp_b <= 1'b0;
      shreg  <= 8'h00;
    end else begin
      if (tick && (tick_cnt == MID_A)) begin
        samp_a <= rx_s;
      end
      if (tick && (tick_cnt == MID_B)) begin
        samp_b <= rx_s;
      end
      if (shift_en) begin
        shreg <= {vote, shreg[7:1]};
      end
    end
  end

  // Registered outputs: one-cycle strobes; data only updates on an accepted byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      uart_data  <= 8'h00;
      uart_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      uart_valid <= load_data;
      frame_err  <= ferr_set;
      if (load_data) begin
        uart_data <= shreg;
      end
    end
  end

endmodule

// File: tb/tb_gps_uart_rx.sv
// Bench for gps_uart_rx: directed serial frames, scoreboard queue of expected strobes,
// independent monitor compares every uart_valid / frame_err pulse against the queue.
module tb_gps_uart_rx;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD_R = 100_000;
  localparam int OS     = 16;
  localparam int BIT    = 16;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       rx_in = 1'b1;
  logic [7:0] uart_data;
  logic       uart_valid;
  logic       frame_err;
  logic       busy;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  gps_uart_rx #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD       (BAUD_R),
    .OVERSAMPLE (OS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .uart_data (uart_data),
    .uart_valid(uart_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Advance n clocks, leaving time 1 unit past the rising edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    cyc(BIT);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic expect_byte(input logic [7:0] d);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = d;
    exp_q.push_back(e);
  endtask

  task automatic expect_ferr(input logic [7:0] held);
    exp_t e;
    e.is_err = 1'b1;
    e.data   = held;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for all expected strobes to be consumed by the monitor.
  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cyc(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected strobes never seen within %0d clks", name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  // Monitor: every strobe must match the head of the expected queue.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (uart_valid && frame_err) begin
          checks++;
          errors++;
          $display("FAIL valid_with_ferr: uart_valid=1 frame_err=1 together, required exclusive");
        end
        if (uart_valid || frame_err) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: valid=%0b ferr=%0b data=%h, none expected",
                     uart_valid, frame_err, uart_data);
          end else begin
            e = exp_q.pop_front();
            check("strobe_kind_ferr", 32'(frame_err), 32'(e.is_err));
            check("uart_data", 32'(uart_data), 32'(e.data));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] gga [7];
    logic [7:0] nmea[7];
    logic [7:0] b31;
    logic       saw_busy;

    gga  = '{8'h24, 8'h47, 8'h50, 8'h47, 8'h47, 8'h41, 8'h2C};
    nmea = '{8'h33, 8'h31, 8'h33, 8'h30, 8'h2C, 8'h4E, 8'h2C};

    // Reset state
    #2;
    check("rst_uart_data", 32'(uart_data), 32'h00);
    check("rst_uart_valid", 32'(uart_valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    cyc(20);

    // 1: single '$'
    expect_byte(8'h24);
    send_byte(8'h24, 1'b1);
    drain("t1_dollar", 100);
    cyc(20);
    check("t1_busy_idle", 32'(busy), 32'd0);

    // 2: "$GPGGA," back to back
    for (int i = 0; i < 7; i++) expect_byte(gga[i]);
    for (int i = 0; i < 7; i++) send_byte(gga[i], 1'b1);
    drain("t2_gpgga", 100);
    cyc(20);

    // 3: 4-clk glitch on an idle line
    rx_in = 1'b0;
    cyc(4);
    rx_in = 1'b1;
    saw_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      saw_busy = saw_busy | busy;
    end
    check("t3_glitch_busy_seen", 32'(saw_busy), 32'd1);
    check("t3_glitch_busy_end", 32'(busy), 32'd0);
    check("t3_data_kept", 32'(uart_data), 32'h2C);

    // 4: 8'h55 with low stop bit, line held low 40 more clks
    expect_ferr(8'h2C);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(((8'h55 >> i) & 8'h01) != 8'h00);
    rx_in = 1'b0;
    cyc(BIT + 40);
    check("t4_busy_while_low", 32'(busy), 32'd1);
    drain("t4_ferr", 1);
    rx_in = 1'b1;
    cyc(6);
    check("t4_busy_after_high", 32'(busy), 32'd0);
    cyc(10);
    expect_byte(8'h4E);
    send_byte(8'h4E, 1'b1);
    drain("t4_after_break", 100);
    cyc(20);

    // 5: reset during data bit 4 of 8'h31
    b31 = 8'h31;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b31[i]);
    rx_in = b31[4];
    cyc(5);
    rst = 1'b0;
    #1;
    check("t5_rst_uart_data", 32'(uart_data), 32'h00);
    check("t5_rst_uart_valid", 32'(uart_valid), 32'd0);
    check("t5_rst_frame_err", 32'(frame_err), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    rx_in = 1'b1;
    cyc(40);
    check("t5_idle_after_rst", 32'(busy), 32'd0);
    expect_byte(8'h32);
    send_byte(8'h32, 1'b1);
    drain("t5_after_rst", 100);
    cyc(20);

    // 6: "3130,N," stream as seen by the parser
    for (int i = 0; i < 7; i++) expect_byte(nmea[i]);
    for (int i = 0; i < 7; i++) send_byte(nmea[i], 1'b1);
    drain("t6_stream", 100);
    cyc(20);
    check("t6_busy_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
